// File: rtl/virtual_ds2431_mem_write_scratchpad.sv
// DS2431 Write Scratchpad (0x0F) handler: latches TA1/TA2/ES and fills the 8-byte scratchpad.
// Define WS_CRC16_EN to return the inverted CRC16 to the master once the row end is written.
module virtual_ds2431_mem_write_scratchpad #(
    parameter logic [7:0]  CMD_CODE  = 8'h0F,
    parameter logic [15:0] MEM_LIMIT = 16'h0090
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       cmdRunTrig,
    input  logic       busRst,
    input  logic       partialByte,
    input  logic [7:0] receiveDat,
    output logic [7:0] transmitDat,
    output logic       nRxTx,
    output logic       transTrig,
    input  logic       ByteTransDone,
    output logic [7:0] TA1,
    output logic [7:0] TA2,
    output logic [7:0] ES,
    output logic       spWrEn,
    output logic [2:0] spWrAddr,
    output logic [7:0] spWrDat,
    output logic       cmdDone,
    output logic       cmdFailed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_TA1,
        S_GET_TA2,
        S_CHK_ADDR,
        S_GET_DATA,
        S_SEND_CRC_L,
        S_SEND_CRC_H,
        S_DONE
    } state_t;

    state_t     r_state;
    logic       r_cmd_d;
    logic       r_btd_d;
    logic [7:0] r_ta1;
    logic [7:0] r_ta2;
    logic [7:0] r_es;
    logic [2:0] r_off;
    logic       r_trans_trig;
    logic       r_sp_wr_en;
    logic [2:0] r_sp_wr_addr;
    logic [7:0] r_sp_wr_dat;
    logic       r_cmd_done;
    logic       r_cmd_failed;

    logic       w_start;
    logic       w_byte_done;
    logic       w_addr_bad;

    assign w_start     = cmdRunTrig & ~r_cmd_d;
    assign w_byte_done = ByteTransDone & ~r_btd_d;
    assign w_addr_bad  = ({r_ta2, r_ta1} >= MEM_LIMIT);

`ifdef WS_CRC16_EN
    logic [15:0] r_crc;
    logic [7:0]  r_tx_dat;
    logic        r_nrxtx;
    logic [15:0] w_crc_next;
    logic [15:0] w_crc_seed;

    // Reflected CRC16 (poly 0xA001), whole byte folded in one cycle.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] dat);
        logic [15:0] c;
        c = crc_in ^ {8'h00, dat};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    assign w_crc_next  = crc16_byte(r_crc, receiveDat);
    assign w_crc_seed  = crc16_byte(16'h0000, CMD_CODE);
    assign transmitDat = r_tx_dat;
    assign nRxTx       = r_nrxtx;
`else
    // CMD_CODE only seeds the CRC; masking it keeps the transmit byte tied low here.
    assign transmitDat = CMD_CODE & 8'h00;
    assign nRxTx       = 1'b0;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state      <= S_IDLE;
            r_cmd_d      <= 1'b0;
            r_btd_d      <= 1'b0;
            r_ta1        <= 8'h00;
            r_ta2        <= 8'h00;
            r_es         <= 8'h00;
            r_off        <= 3'd0;
            r_trans_trig <= 1'b0;
            r_sp_wr_en   <= 1'b0;
            r_sp_wr_addr <= 3'd0;
            r_sp_wr_dat  <= 8'h00;
            r_cmd_done   <= 1'b0;
            r_cmd_failed <= 1'b0;
`ifdef WS_CRC16_EN
            r_crc        <= 16'h0000;
            r_tx_dat     <= 8'h00;
            r_nrxtx      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout, so every branch reads the pre-edge register values.
            r_cmd_d    <= cmdRunTrig;
            r_btd_d    <= ByteTransDone;
            r_sp_wr_en <= 1'b0;

            if (w_start) begin
                r_state      <= S_GET_TA1;
                r_cmd_done   <= 1'b0;
                r_cmd_failed <= 1'b0;
                r_trans_trig <= 1'b0;
                r_es[7]      <= 1'b0;
`ifdef WS_CRC16_EN
                r_crc        <= w_crc_seed;
                r_tx_dat     <= 8'h00;
                r_nrxtx      <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_GET_TA1: begin
                        if (busRst) begin
                            r_trans_trig <= 1'b0;
                            r_cmd_failed <= 1'b1;
                            r_state      <= S_IDLE;
                        end else if (w_byte_done) begin
                            r_trans_trig <= 1'b0;
                            r_ta1        <= receiveDat;
`ifdef WS_CRC16_EN
                            r_crc        <= w_crc_next;
`endif
                            r_state      <= S_GET_TA2;
                        end else begin
                            r_trans_trig <= 1'b1;
                        end
                    end

                    S_GET_TA2: begin
                        if (busRst) begin
                            r_trans_trig <= 1'b0;
                            r_cmd_failed <= 1'b1;
                            r_state      <= S_IDLE;
                        end else if (w_byte_done) begin
                            r_trans_trig <= 1'b0;
                            r_ta2        <= receiveDat;
`ifdef WS_CRC16_EN
                            r_crc        <= w_crc_next;
`endif
                            r_state      <= S_CHK_ADDR;
                        end else begin
                            r_trans_trig <= 1'b1;
                        end
                    end

                    S_CHK_ADDR: begin
                        if (w_addr_bad) begin
                            r_cmd_failed <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_off     <= r_ta1[2:0];
                            r_es[2:0] <= r_ta1[2:0];
                            r_es[5]   <= 1'b1;
                            r_state   <= S_GET_DATA;
                        end
                    end

                    S_GET_DATA: begin
                        if (busRst) begin
                            // ES[5] is still 1 here if no data byte has landed yet.
                            r_trans_trig <= 1'b0;
                            r_es[5]      <= partialByte | r_es[5];
                            r_cmd_done   <= 1'b1;
                            r_state      <= S_IDLE;
                        end else if (w_byte_done) begin
                            r_trans_trig <= 1'b0;
                            r_sp_wr_en   <= 1'b1;
                            r_sp_wr_addr <= r_off;
                            r_sp_wr_dat  <= receiveDat;
                            r_es[2:0]    <= r_off;
                            r_es[5]      <= 1'b0;
`ifdef WS_CRC16_EN
                            r_crc        <= w_crc_next;
`endif
                            if (r_off == 3'd7) begin
`ifdef WS_CRC16_EN
                                r_tx_dat <= ~w_crc_next[7:0];
                                r_nrxtx  <= 1'b1;
                                r_state  <= S_SEND_CRC_L;
`else
                                r_state  <= S_DONE;
`endif
                            end else begin
                                r_off <= r_off + 3'd1;
                            end
                        end else begin
                            r_trans_trig <= 1'b1;
                        end
                    end

`ifdef WS_CRC16_EN
                    S_SEND_CRC_L: begin
                        if (busRst) begin
                            r_trans_trig <= 1'b0;
                            r_nrxtx      <= 1'b0;
                            r_cmd_done   <= 1'b1;
                            r_state      <= S_IDLE;
                        end else if (w_byte_done) begin
                            r_trans_trig <= 1'b0;
                            r_tx_dat     <= ~r_crc[15:8];
                            r_state      <= S_SEND_CRC_H;
                        end else begin
                            r_trans_trig <= 1'b1;
                        end
                    end

                    S_SEND_CRC_H: begin
                        if (busRst) begin
                            r_trans_trig <= 1'b0;
                            r_nrxtx      <= 1'b0;
                            r_cmd_done   <= 1'b1;
                            r_state      <= S_IDLE;
                        end else if (w_byte_done) begin
                            r_trans_trig <= 1'b0;
                            r_nrxtx      <= 1'b0;
                            r_tx_dat     <= 8'h00;
                            r_state      <= S_DONE;
                        end else begin
                            r_trans_trig <= 1'b1;
                        end
                    end
`endif

                    S_DONE: begin
                        r_cmd_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end

                    default: begin
                        r_trans_trig <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign transTrig = r_trans_trig;
    assign TA1       = r_ta1;
    assign TA2       = r_ta2;
    assign ES        = r_es;
    assign spWrEn    = r_sp_wr_en;
    assign spWrAddr  = r_sp_wr_addr;
    assign spWrDat   = r_sp_wr_dat;
    assign cmdDone   = r_cmd_done;
    assign cmdFailed = r_cmd_failed;

endmodule

// File: tb/tb_virtual_ds2431_mem_write_scratchpad.sv
// Bench for the Write Scratchpad handler: vector table, hand-written corner sequences and
// randomized commands checked against a reference model (CRC bytes checked when WS_CRC16_EN is set).
`timescale 1ns/1ps
module tb_virtual_ds2431_mem_write_scratchpad;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       cmdRunTrig = 1'b0;
    logic       busRst = 1'b0;
    logic       partialByte = 1'b0;
    logic [7:0] receiveDat = 8'h00;
    logic       ByteTransDone = 1'b0;
    logic [7:0] transmitDat;
    logic       nRxTx;
    logic       transTrig;
    logic [7:0] TA1;
    logic [7:0] TA2;
    logic [7:0] ES;
    logic       spWrEn;
    logic [2:0] spWrAddr;
    logic [7:0] spWrDat;
    logic       cmdDone;
    logic       cmdFailed;

    always #5 clk = ~clk;

    virtual_ds2431_mem_write_scratchpad dut (
        .clk           (clk),
        .nRst          (nRst),
        .cmdRunTrig    (cmdRunTrig),
        .busRst        (busRst),
        .partialByte   (partialByte),
        .receiveDat    (receiveDat),
        .transmitDat   (transmitDat),
        .nRxTx         (nRxTx),
        .transTrig     (transTrig),
        .ByteTransDone (ByteTransDone),
        .TA1           (TA1),
        .TA2           (TA2),
        .ES            (ES),
        .spWrEn        (spWrEn),
        .spWrAddr      (spWrAddr),
        .spWrDat       (spWrDat),
        .cmdDone       (cmdDone),
        .cmdFailed     (cmdFailed)
    );

    typedef struct {
        logic [7:0]  ta1;
        logic [7:0]  ta2;
        logic [63:0] data;
        int          nd;
        bit          brst;
        bit          partial;
        logic [7:0]  exp_es;
        bit          exp_done;
        bit          exp_fail;
        int          exp_nwr;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] wr_q[$];
    logic [7:0]  m_ta1 = 8'h00;
    logic [7:0]  m_ta2 = 8'h00;
    logic [7:0]  m_es  = 8'h00;
    vec_t        tbl[9];

    always @(negedge clk) if (spWrEn === 1'b1) wr_q.push_back({spWrAddr, spWrDat});

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

`ifdef WS_CRC16_EN
    typedef logic [7:0] byte_q_t[$];

    // Serial shift-register CRC16 (x16+x15+x2+1), one message bit at a time, LSB first.
    function automatic logic [15:0] ref_crc(input byte_q_t msg);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (msg[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ msg[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction
`endif

    task automatic wait_trig(input string name);
        int n;
        n = 0;
        while (transTrig !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_trig"}, transTrig, 1);
    endtask

    task automatic xfer(input string name, input logic [7:0] rx, input logic exp_nrxtx,
                        output logic [7:0] tx);
        tx = 8'h00;
        wait_trig(name);
        if (transTrig === 1'b1) begin
            check({name, "_nRxTx"}, nRxTx, exp_nrxtx);
            tx            = transmitDat;
            receiveDat    = rx;
            ByteTransDone = 1'b1;
            @(negedge clk);
            ByteTransDone = 1'b0;
            check({name, "_trig_drop"}, transTrig, 0);
        end
    endtask

    task automatic start_cmd(input string name);
        cmdRunTrig = 1'b1;
        @(negedge clk);
        cmdRunTrig = 1'b0;
        check({name, "_start_clr"}, {cmdDone, cmdFailed}, 0);
    endtask

    task automatic apply(input string name, input vec_t v);
        logic [7:0] tx;
        int         n;
        wr_q.delete();
        start_cmd(name);
        xfer({name, "_ta1"}, v.ta1, 1'b0, tx);
        xfer({name, "_ta2"}, v.ta2, 1'b0, tx);
        for (int i = 0; i < v.nd; i++) xfer({name, "_dat"}, v.data[8*i +: 8], 1'b0, tx);
        if (v.brst) begin
            wait_trig({name, "_in_data"});
            busRst      = 1'b1;
            partialByte = v.partial;
            @(negedge clk);
            busRst      = 1'b0;
            partialByte = 1'b0;
        end
`ifdef WS_CRC16_EN
        if (!v.brst && !v.exp_fail) begin
            byte_q_t     msg;
            logic [15:0] crc;
            msg.push_back(8'h0F);
            msg.push_back(v.ta1);
            msg.push_back(v.ta2);
            for (int i = 0; i < v.nd; i++) msg.push_back(v.data[8*i +: 8]);
            crc = ref_crc(msg);
            xfer({name, "_crcl"}, 8'h00, 1'b1, tx);
            check({name, "_crc_lo"}, tx, ~crc[7:0]);
            xfer({name, "_crch"}, 8'h00, 1'b1, tx);
            check({name, "_crc_hi"}, tx, ~crc[15:8]);
        end
`endif
        n = 0;
        while (cmdDone !== 1'b1 && cmdFailed !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (v.exp_fail) check({name, "_fail_lat"}, n, 1);
        check({name, "_done"}, cmdDone, v.exp_done);
        check({name, "_failed"}, cmdFailed, v.exp_fail);
        check({name, "_es"}, ES, v.exp_es);
        check({name, "_ta"}, {TA2, TA1}, {v.ta2, v.ta1});
        check({name, "_idle"}, {transTrig, nRxTx}, 0);
        check({name, "_nwr"}, wr_q.size(), v.exp_nwr);
        for (int i = 0; i < v.exp_nwr && i < wr_q.size(); i++)
            check({name, "_wr"}, wr_q[i], {3'(v.ta1[2:0] + 3'(i)), v.data[8*i +: 8]});
        m_ta1 = v.ta1;
        m_ta2 = v.ta2;
        m_es  = v.exp_es;
        @(negedge clk);
    endtask

    // Reference model: expected results from the address rules and row arithmetic.
    function automatic vec_t model(input vec_t v, input logic [7:0] es_prev);
        vec_t r;
        int   off;
        r        = v;
        off      = int'(v.ta1[2:0]);
        r.exp_fail = ({v.ta2, v.ta1} >= 16'h0090);
        r.exp_done = !r.exp_fail;
        r.exp_nwr  = r.exp_fail ? 0 : v.nd;
        if (r.exp_fail)
            r.exp_es = es_prev;
        else if (v.brst)
            r.exp_es = {2'b00, (v.partial || v.nd == 0), 2'b00,
                        3'((v.nd == 0) ? off : off + v.nd - 1)};
        else
            r.exp_es = 8'h07;
        return r;
    endfunction

    initial begin
        logic [7:0] tx;
        vec_t       v;
        int         rowlen;

        tbl[0] = '{8'h00, 8'h00, 64'h8877665544332211, 8, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 8};
        tbl[1] = '{8'h8D, 8'h00, 64'h0000000000A3A2A1, 3, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 3};
        tbl[2] = '{8'h90, 8'h00, 64'h0, 0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1, 0};
        tbl[3] = '{8'h10, 8'h00, 64'h000000000000BBAA, 2, 1'b1, 1'b1, 8'h21, 1'b1, 1'b0, 2};
        tbl[4] = '{8'h13, 8'h00, 64'h0, 0, 1'b1, 1'b0, 8'h23, 1'b1, 1'b0, 0};
        tbl[5] = '{8'h8F, 8'h00, 64'h000000000000005A, 1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1};
        tbl[6] = '{8'h00, 8'h01, 64'h0, 0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1, 0};
        tbl[7] = '{8'h0A, 8'h00, 64'h00000000000000C3, 1, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1};
        tbl[8] = '{8'h0A, 8'h00, 64'h0000000000E5D4C3, 3, 1'b1, 1'b1, 8'h24, 1'b1, 1'b0, 3};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {transmitDat, nRxTx, transTrig, TA1, TA2, ES, spWrEn, spWrAddr, spWrDat, cmdDone, cmdFailed}, 0);
        nRst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Bus reset while the second address byte is pending.
        wr_q.delete();
        start_cmd("rst_ta2");
        xfer("rst_ta2_ta1", 8'h44, 1'b0, tx);
        wait_trig("rst_ta2_wait");
        busRst = 1'b1;
        @(negedge clk);
        busRst = 1'b0;
        @(negedge clk);
        check("rst_ta2_failed", {cmdDone, cmdFailed}, 2'b01);
        check("rst_ta2_ta", {TA2, TA1}, {m_ta2, 8'h44});
        check("rst_ta2_es", ES, m_es);
        check("rst_ta2_nwr", wr_q.size(), 0);
        m_ta1 = 8'h44;
        @(negedge clk);

        // Asynchronous reset in the middle of the data phase.
        start_cmd("async");
        xfer("async_ta1", 8'h20, 1'b0, tx);
        xfer("async_ta2", 8'h00, 1'b0, tx);
        xfer("async_d0", 8'h31, 1'b0, tx);
        xfer("async_d1", 8'h32, 1'b0, tx);
        #2 nRst = 1'b0;
        #1 check("async_outputs",
                 {transmitDat, nRxTx, transTrig, TA1, TA2, ES, spWrEn, spWrAddr, spWrDat, cmdDone, cmdFailed}, 0);
        @(negedge clk);
        nRst  = 1'b1;
        m_es  = 8'h00;
        m_ta1 = 8'h00;
        m_ta2 = 8'h00;
        @(negedge clk);
        apply("after_rst", tbl[0]);

        // Randomized commands against the reference model.
        for (int k = 0; k < 40; k++) begin
            v.ta2     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            v.ta1     = 8'($urandom_range(0, 255));
            v.data    = {$urandom, $urandom};
            v.partial = 1'($urandom_range(0, 1));
            rowlen    = 8 - int'(v.ta1[2:0]);
            if ({v.ta2, v.ta1} >= 16'h0090) begin
                v.brst = 1'b0;
                v.nd   = 0;
            end else begin
                v.brst = ($urandom_range(0, 2) == 0);
                v.nd   = v.brst ? int'($urandom_range(0, rowlen - 1)) : rowlen;
            end
            v = model(v, m_es);
            apply($sformatf("rnd%0d", k), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/virtual_ds2431_mem_write_scratchpad.md
Name: virtual_ds2431_mem_write_scratchpad

Overview:
- Command handler for DS2431 Write Scratchpad (0x0F).
- Sits directly upstream of the Copy Scratchpad handler: it latches the target address TA1/TA2 and the status byte ES that Copy Scratchpad later matches.
- Fills the 8-byte scratchpad through a write port.
- Optionally returns inverted CRC16 to the master when the row end is reached.
- Uses the same byte-transfer handshake as the other command handlers: transTrig/ByteTransDone, with nRxTx selecting direction.

Parameters:
- CMD_CODE, 8'h0F, command byte seeded into CRC16.
- MEM_LIMIT, 16'h0090, first invalid target address.

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous, active-low reset
- cmdRunTrig  in  1  rising edge starts command (edge-detected internally)
- busRst  in  1  1-Wire reset pulse seen; level, sampled each clk
- partialByte  in  1  bit engine holds 1..7 bits of an unfinished byte
- receiveDat  in  8  byte from master, valid at ByteTransDone rise
- transmitDat  out  8  byte to master
- nRxTx  out  1  0 = receive, 1 = transmit
- transTrig  out  1  request a byte transfer
- ByteTransDone  in  1  rising edge = byte transfer complete (edge-detected)
- TA1  out  8  target address low
- TA2  out  8  target address high
- ES  out  8  {AA, 1'b0, PF, 2'b00, E2:E0}
- spWrEn  out  1  one-cycle scratchpad write strobe
- spWrAddr  out  3  scratchpad offset
- spWrDat  out  8  scratchpad data
- cmdDone  out  1  command finished normally (held until next start)
- cmdFailed  out  1  command aborted on address error (held until next start)

Behaviour:
- Reset: all outputs 0; TA1=TA2=ES=0; CRC=0; state IDLE.

Start (cmdRunTrig rise):
- Clear cmdDone, cmdFailed, transTrig, ES[7] (AA) and the CRC.
- Load CRC with CRC16(0, CMD_CODE).
- Go to GET_TA1.
- A start pulse in any state restarts the command.

Handshake:
- In each receive/transmit state, transTrig=1 until the cycle ByteTransDone rises.
- That cycle: transTrig=0, byte consumed, state advances.
- nRxTx=1 only in the SEND states.

States:
- GET_TA1: store TA1; update CRC.
- GET_TA2: store TA2; update CRC.
- CHK_ADDR (1 cycle):
  - {TA2,TA1} >= MEM_LIMIT -> cmdFailed=1, IDLE.
  - else off=TA1[2:0], ES[2:0]=TA1[2:0], ES[5]=1, GET_DATA.
- GET_DATA, per byte:
  - spWrEn=1 for 1 cycle, spWrAddr=off, spWrDat=receiveDat.
  - ES[2:0]=off, ES[5]=0, CRC updated.
  - off==7 -> SEND_CRC_L (or DONE without CRC feature); else off++.
- SEND_CRC_L: transmitDat=~CRC[7:0].
- SEND_CRC_H: transmitDat=~CRC[15:8], then DONE.
- DONE: cmdDone=1 for the held duration, IDLE.

CRC16:
- Polynomial x16+x15+x2+1, LSB-first (reflected 0xA001), init 0.
- Byte update computed combinationally in the accept cycle.

busRst while in GET_DATA:
- ES[5] = partialByte OR (no data byte written yet); ES[2:0] keeps the last written offset (TA1[2:0] if none).
- cmdDone=1, IDLE.
- The scratchpad is not written for an incomplete byte.

busRst in other states:
- GET_TA1/GET_TA2: cmdFailed=1, TA and ES unchanged from the last latched values, IDLE.
- SEND states: cmdDone=1 (data already committed), IDLE.

ByteTransDone outside an active state is ignored.

TA1, TA2 and ES are held stable after the command ends; they are consumed by Copy Scratchpad.

Optional Feature:
- Macro WS_CRC16_EN.
- Defined: CRC16 computed and both SEND states present; the master reads the inverted CRC after byte 7.
- Undefined: CRC logic removed; transmitDat tied 0; nRxTx constantly 0; after offset-7 write, go directly to DONE.

Test Plan:
1. Start; send TA1=0x00, TA2=0x00, data 0x11..0x88 -> 8 spWrEn strobes at addr 0..7; ES=0x07; with WS_CRC16_EN, two transmit bytes equal ~CRC16 from a model over {0x0F,0x00,0x00,0x11..0x88}, low byte first; cmdDone=1.
2. TA1=0x8D, TA2=0x00, data 0xA1,0xA2,0xA3 -> writes at offsets 5,6,7; ES=0x07; CRC sent; TA1=0x8D held.
3. TA1=0x90, TA2=0x00 -> no spWrEn; cmdFailed=1 the cycle after TA2; cmdDone=0.
4. TA1=0x10, data 0xAA,0xBB, then busRst with partialByte=1 -> writes at 0,1; ES=0x21; cmdDone=1; no CRC transmitted.
5. TA1=0x13, busRst before any data, partialByte=0 -> ES=0x23; no writes; cmdDone=1.
6. nRst asserted mid-GET_DATA -> all outputs 0 asynchronously; a new cmdRunTrig afterwards starts cleanly from GET_TA1.
